// File: rtl/ddr4_v2_2_24_tg_fifo_pkg.sv
// Shared types, defaults and the modulo pointer helper for the TG FIFO.
package ddr4_v2_2_24_tg_fifo_pkg;

  typedef enum logic {
    TG_FIFO_REG  = 1'b0,
    TG_FIFO_FWFT = 1'b1
  } tg_fifo_mode_e;

  localparam int TG_FIFO_DEF_DEPTH = 4;
  localparam int TG_FIFO_DEF_AE    = 1;

  // Depth need not be a power of two, so wrap explicitly at depth-1.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/ddr4_v2_2_24_tg_fifo_ptr.sv
// Modulo-DEPTH pointer with increment enable; used for both read and write sides.
module ddr4_v2_2_24_tg_fifo_ptr
  import ddr4_v2_2_24_tg_fifo_pkg::*;
#(
  parameter int DEPTH = TG_FIFO_DEF_DEPTH,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_inc,
  output logic [PW-1:0] o_ptr
);

  logic [PW-1:0] r_ptr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_ptr <= '0;
    else if (i_inc)
      r_ptr <= PW'(wrap_inc(32'(r_ptr), DEPTH));
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/ddr4_v2_2_24_tg_fifo_ext.sv
// Synchronous TG FIFO with FWFT or registered read, programmable almost flags,
// occupancy output and sticky overflow/underflow errors.
module ddr4_v2_2_24_tg_fifo_ext
  import ddr4_v2_2_24_tg_fifo_pkg::*;
#(
  parameter int TCQ       = 100,
  parameter int WIDTH     = 576,
  parameter int DEPTH     = TG_FIFO_DEF_DEPTH,
  parameter int CNTW      = $clog2(DEPTH + 1),
  parameter int FWFT      = 1,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = TG_FIFO_DEF_AE
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wren,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_rden,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_dout_vld,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_almost_full,
  output logic             o_almost_empty,
  output logic [CNTW-1:0]  o_level,
  input  logic             i_err_clr,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam tg_fifo_mode_e MODE = (FWFT != 0) ? TG_FIFO_FWFT : TG_FIFO_REG;

  if (DEPTH < 2 || AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH || TCQ < 0) begin : g_bad_cfg
    $error("ddr4_v2_2_24_tg_fifo_ext: illegal DEPTH/AF_THRESH/AE_THRESH/TCQ combination");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    w_wrptr, w_rdptr;
  logic [CNTW-1:0]  r_level, w_level_nxt;
  logic             r_full, r_empty, r_almost_full, r_almost_empty;
  logic             r_overflow, r_underflow;
  logic             w_rd_acc, w_wr_acc;

  // A full FIFO still takes a write when the head leaves in the same cycle;
  // an empty FIFO never bypasses a same-cycle write to the reader.
  assign w_rd_acc    = i_rden & ~r_empty;
  assign w_wr_acc    = i_wren & (~r_full | w_rd_acc);
  assign w_level_nxt = r_level + CNTW'(w_wr_acc) - CNTW'(w_rd_acc);

  ddr4_v2_2_24_tg_fifo_ptr #(.DEPTH(DEPTH), .PW(AW)) u_wrptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_wr_acc),
    .o_ptr   (w_wrptr)
  );

  ddr4_v2_2_24_tg_fifo_ptr #(.DEPTH(DEPTH), .PW(AW)) u_rdptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_rd_acc),
    .o_ptr   (w_rdptr)
  );

  always_ff @(posedge i_clk) begin
    if (w_wr_acc)
      r_mem[w_wrptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_level        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_level        <= w_level_nxt;
      r_full         <= (w_level_nxt == CNTW'(DEPTH));
      r_empty        <= (w_level_nxt == '0);
      r_almost_full  <= (w_level_nxt >= CNTW'(AF_THRESH));
      r_almost_empty <= (w_level_nxt <= CNTW'(AE_THRESH));
    end
  end

  // A fresh error in the clearing cycle must not be lost.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_wren & ~w_wr_acc)
        r_overflow <= 1'b1;
      else if (i_err_clr)
        r_overflow <= 1'b0;
      if (i_rden & ~w_rd_acc)
        r_underflow <= 1'b1;
      else if (i_err_clr)
        r_underflow <= 1'b0;
    end
  end

  if (MODE == TG_FIFO_FWFT) begin : g_fwft
    assign o_dout     = r_mem[w_rdptr];
    assign o_dout_vld = ~r_empty;
  end else begin : g_reg
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_vld;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_dout     <= '0;
        r_dout_vld <= 1'b0;
      end else begin
        r_dout_vld <= w_rd_acc;
        if (w_rd_acc)
          r_dout <= r_mem[w_rdptr];
      end
    end

    assign o_dout     = r_dout;
    assign o_dout_vld = r_dout_vld;
  end

  assign o_full         = r_full;
  assign o_empty        = r_empty;
  assign o_almost_full  = r_almost_full;
  assign o_almost_empty = r_almost_empty;
  assign o_level        = r_level;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_ddr4_v2_2_24_tg_fifo_ext.sv
// Directed bench: a DEPTH=5 FWFT instance and a DEPTH=4 registered-read instance.
module tb_ddr4_v2_2_24_tg_fifo_ext;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // FWFT instance, DEPTH=5 (AF=4, AE=1)
  logic         f_wren, f_rden, f_err_clr;
  logic [W-1:0] f_din, f_dout;
  logic         f_vld, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [2:0]   f_level;

  // registered-read instance, DEPTH=4 (AF=3, AE=1)
  logic         r_wren, r_rden, r_err_clr;
  logic [W-1:0] r_din, r_dout;
  logic         r_vld, r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
  logic [2:0]   r_level;

  ddr4_v2_2_24_tg_fifo_ext #(.WIDTH(W), .DEPTH(5), .FWFT(1)) u_fwft (
    .i_clk(clk), .i_rst_n(rst_n), .i_wren(f_wren), .i_din(f_din), .i_rden(f_rden),
    .o_dout(f_dout), .o_dout_vld(f_vld), .o_full(f_full), .o_empty(f_empty),
    .o_almost_full(f_af), .o_almost_empty(f_ae), .o_level(f_level),
    .i_err_clr(f_err_clr), .o_overflow(f_ovf), .o_underflow(f_udf)
  );

  ddr4_v2_2_24_tg_fifo_ext #(.WIDTH(W), .DEPTH(4), .FWFT(0)) u_reg (
    .i_clk(clk), .i_rst_n(rst_n), .i_wren(r_wren), .i_din(r_din), .i_rden(r_rden),
    .o_dout(r_dout), .o_dout_vld(r_vld), .o_full(r_full), .o_empty(r_empty),
    .o_almost_full(r_af), .o_almost_empty(r_ae), .o_level(r_level),
    .i_err_clr(r_err_clr), .o_overflow(r_ovf), .o_underflow(r_udf)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic f_idle();
    f_wren = 1'b0; f_rden = 1'b0; f_err_clr = 1'b0;
  endtask

  task automatic f_write(input logic [W-1:0] d);
    f_wren = 1'b1; f_din = d; step(); f_wren = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    f_idle(); f_din = '0;
    r_wren = 1'b0; r_rden = 1'b0; r_err_clr = 1'b0; r_din = '0;
    step(); step();
    rst_n = 1'b1;

    chk("rst_empty", 32'(f_empty), 1);
    chk("rst_full", 32'(f_full), 0);
    chk("rst_level", 32'(f_level), 0);
    chk("rst_af", 32'(f_af), 0);
    chk("rst_ae", 32'(f_ae), 1);
    chk("rst_ovf_udf", {30'd0, f_ovf, f_udf}, 0);
    chk("rst_vld", 32'(f_vld), 0);
    chk("rst_reg_dout", 32'(r_dout), 0);
    chk("rst_reg_vld", 32'(r_vld), 0);

    // fill 1..5, then drain in order
    for (int i = 1; i <= 5; i++) f_write(W'(i));
    chk("fill_full", 32'(f_full), 1);
    chk("fill_level", 32'(f_level), 5);
    chk("fill_af", 32'(f_af), 1);
    chk("fill_ae", 32'(f_ae), 0);
    for (int i = 1; i <= 5; i++) begin
      f_rden = 1'b1;
      chk("drain_data", 32'(f_dout), i);
      step();
    end
    f_idle();
    chk("drain_empty", 32'(f_empty), 1);
    chk("drain_level", 32'(f_level), 0);
    chk("drain_ae", 32'(f_ae), 1);

    // simultaneous write+read while full
    for (int i = 0; i < 5; i++) f_write(W'(16'h11 + i));
    f_wren = 1'b1; f_din = 16'h16; f_rden = 1'b1;
    step(); f_idle();
    chk("fullrw_level", 32'(f_level), 5);
    chk("fullrw_full", 32'(f_full), 1);
    chk("fullrw_ovf", 32'(f_ovf), 0);
    for (int i = 0; i < 5; i++) begin
      f_rden = 1'b1;
      chk("fullrw_data", 32'(f_dout), 16'h12 + i);
      step();
    end
    f_idle();
    chk("fullrw_empty", 32'(f_empty), 1);

    // simultaneous write+read while empty: read rejected, no bypass
    f_wren = 1'b1; f_din = 16'h21; f_rden = 1'b1;
    step(); f_idle();
    chk("emptyrw_udf", 32'(f_udf), 1);
    chk("emptyrw_level", 32'(f_level), 1);
    chk("emptyrw_empty", 32'(f_empty), 0);
    f_err_clr = 1'b1; step(); f_idle();
    chk("errclr_udf", 32'(f_udf), 0);
    f_rden = 1'b1;
    chk("emptyrw_data", 32'(f_dout), 16'h21);
    step(); f_idle();
    chk("emptyrw_drained", 32'(f_empty), 1);

    // overflow: rejected write, error beats same-cycle clear
    for (int i = 0; i < 5; i++) f_write(W'(16'h31 + i));
    f_write(16'h99);
    chk("ovf_set", 32'(f_ovf), 1);
    chk("ovf_level", 32'(f_level), 5);
    f_wren = 1'b1; f_err_clr = 1'b1; step(); f_idle();
    chk("ovf_wins_clr", 32'(f_ovf), 1);
    f_err_clr = 1'b1; step(); f_idle();
    chk("ovf_clr", 32'(f_ovf), 0);
    f_rden = 1'b1;
    chk("ovf_head", 32'(f_dout), 16'h31);
    for (int i = 0; i < 5; i++) step();
    f_idle();
    chk("ovf_drained", 32'(f_level), 0);

    // 12 write/read pairs across the wrap against a queue model
    q.delete();
    for (int i = 0; i < 2; i++) begin
      f_write(W'(16'h40 + i));
      q.push_back(W'(16'h40 + i));
    end
    for (int i = 2; i < 14; i++) begin
      f_wren = 1'b1; f_din = W'(16'h40 + i); f_rden = 1'b1;
      chk("wrap_data", 32'(f_dout), 32'(q[0]));
      step();
      void'(q.pop_front());
      q.push_back(W'(16'h40 + i));
      chk("wrap_level", 32'(f_level), q.size());
    end
    f_idle();
    while (q.size() > 0) begin
      f_rden = 1'b1;
      chk("wrap_tail", 32'(f_dout), 32'(q[0]));
      step();
      void'(q.pop_front());
    end
    f_idle();
    chk("wrap_empty", 32'(f_empty), 1);

    // reset with level=3 discards contents
    for (int i = 0; i < 3; i++) f_write(W'(16'h50 + i));
    chk("prerst_level", 32'(f_level), 3);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("midrst_empty", 32'(f_empty), 1);
    chk("midrst_level", 32'(f_level), 0);
    chk("midrst_flags", {28'd0, f_full, f_af, f_ae, f_ovf}, 32'b0010);
    f_rden = 1'b1; step(); f_idle();
    chk("midrst_udf", 32'(f_udf), 1);
    chk("midrst_level2", 32'(f_level), 0);

    // registered-read mode
    r_wren = 1'b1; r_din = 16'hA; step();
    r_din = 16'hB; step();
    r_wren = 1'b0;
    chk("reg_level", 32'(r_level), 2);
    r_rden = 1'b1; step(); r_rden = 1'b0;
    chk("reg_dout_a", 32'(r_dout), 16'hA);
    chk("reg_vld_a", 32'(r_vld), 1);
    step();
    chk("reg_hold_a", 32'(r_dout), 16'hA);
    chk("reg_idle_vld", 32'(r_vld), 0);
    r_rden = 1'b1; step(); r_rden = 1'b0;
    chk("reg_dout_b", 32'(r_dout), 16'hB);
    chk("reg_vld_b", 32'(r_vld), 1);
    chk("reg_empty", 32'(r_empty), 1);
    r_rden = 1'b1; step(); r_rden = 1'b0;
    chk("reg_udf", 32'(r_udf), 1);
    chk("reg_udf_vld", 32'(r_vld), 0);
    chk("reg_udf_hold", 32'(r_dout), 16'hB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
